// File: rtl/t2_lane_arbiter.sv
// Round-robin arbiter sharing one registered output slot among NREQ valid/ready requesters.
// Define T2ARB_LOCK_EN to add in_last and hold the grant across a multi-beat packet.
module t2_lane_arbiter #(
  parameter int DW   = 46,
  parameter int NREQ = 4,
  parameter int SW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   in_valid,
  input  logic [NREQ*DW-1:0] in_data,
`ifdef T2ARB_LOCK_EN
  input  logic [NREQ-1:0]   in_last,
`endif
  output logic [NREQ-1:0]   in_ready,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output logic [SW-1:0]     out_src,
  output logic              out_last,
  input  logic              out_ready
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t        state;
  logic [SW-1:0] rr_ptr;
  logic          accept_en;
  logic          win_found;
  logic [SW-1:0] win_idx;
  logic          win_last;
  logic          grant;

`ifdef T2ARB_LOCK_EN
  logic          lock;
  logic [SW-1:0] lock_src;
`endif

  assign accept_en = (state == S_EMPTY) | out_ready;

  // Cyclic scan starting just after the last winner; a held lock narrows eligibility to lock_src.
  always_comb begin
    int            j;
    logic [SW-1:0] cand;
    logic          eligible;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    cand      = '0;
    eligible  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      cand     = SW'(j);
      eligible = in_valid[cand];
`ifdef T2ARB_LOCK_EN
      if (lock && (cand != lock_src)) eligible = 1'b0;
`endif
      if (!win_found && eligible) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef T2ARB_LOCK_EN
  assign win_last = in_last[win_idx];
`else
  assign win_last = 1'b1;
`endif

  assign grant = rst_n & accept_en & win_found;

  always_comb begin
    in_ready = '0;
    if (grant) in_ready[win_idx] = 1'b1;
  end

  // Output slot: loads on every accepted beat, drains when downstream takes it without a refill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
      rr_ptr    <= SW'(NREQ - 1);
`ifdef T2ARB_LOCK_EN
      lock      <= 1'b0;
      lock_src  <= '0;
`endif
    end else begin
      if (grant) begin
        state     <= S_FULL;
        out_valid <= 1'b1;
        out_data  <= in_data[int'(win_idx)*DW +: DW];
        out_src   <= win_idx;
        out_last  <= win_last;
`ifdef T2ARB_LOCK_EN
        if (win_last) begin
          rr_ptr <= win_idx;
          lock   <= 1'b0;
        end else begin
          lock     <= 1'b1;
          lock_src <= win_idx;
        end
`else
        rr_ptr    <= win_idx;
`endif
      end else if ((state == S_FULL) && out_ready) begin
        state     <= S_EMPTY;
        out_valid <= 1'b0;
      end
    end
  end

endmodule
